// File: rtl/mac_group_sequencer.sv
// Job sequencer for a column of NUM_GROUPS four-MAC groups: weight load, activation streaming,
// pipeline tracking and delayed-clock gating. Define MAC_ERR_STATS_EN to enable err_count.
module mac_group_sequencer #(
   parameter int unsigned NUM_GROUPS = 4,
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned ERR_W      = 16,
   localparam int unsigned NM        = 4 * NUM_GROUPS,
   localparam int unsigned LAT       = NM,
   localparam int unsigned AW        = $clog2(NM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [LEN_W-1:0] vec_len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             weight_we_o,
   output logic [AW-1:0]    weight_addr_o,
   input  logic             act_valid_i,
   output logic             act_ready_o,
   output logic             act_fire_o,
   output logic             delay_clk_en_o,
   input  logic             col_error_i,
   output logic             out_valid_o,
   output logic [ERR_W-1:0] err_count_o
);

   typedef enum logic [2:0] {
      StIdle,
      StLoadW,
      StStream,
      StDrain,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] acc_q, acc_d;
   logic [AW-1:0]    waddr_q, waddr_d;
   logic [LAT-1:0]   tracker_q, tracker_d;
   logic             fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         len_q     <= '0;
         acc_q     <= '0;
         waddr_q   <= '0;
         tracker_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         acc_q     <= acc_d;
         waddr_q   <= waddr_d;
         tracker_q <= tracker_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      acc_d          = acc_q;
      waddr_d        = waddr_q;
      fire           = 1'b0;
      busy_o         = 1'b1;
      done_o         = 1'b0;
      weight_we_o    = 1'b0;
      act_ready_o    = 1'b0;
      delay_clk_en_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy_o = 1'b0;
            if (start_i) begin
               len_d   = vec_len_i;
               acc_d   = '0;
               waddr_d = '0;
               state_d = StLoadW;
            end
         end
         StLoadW: begin
            weight_we_o = 1'b1;
            if (waddr_q == AW'(NM - 1)) begin
               waddr_d = '0;
               state_d = (len_q == '0) ? StDrain : StStream;
            end else begin
               waddr_d = waddr_q + AW'(1);
            end
         end
         StStream: begin
            delay_clk_en_o = 1'b1;
            act_ready_o    = (acc_q < len_q);
            fire           = act_valid_i & act_ready_o;
            if (fire) begin
               acc_d = acc_q + LEN_W'(1);
               if (acc_d == len_q) state_d = StDrain;
            end
         end
         StDrain: begin
            delay_clk_en_o = 1'b1;
            // Last result has left the column once the tracker holds no in-flight vectors
            if (tracker_q == '0) state_d = StDone;
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Bubbles shift in as zeros so result order and spacing mirror the fire pattern
   assign tracker_d     = {tracker_q[LAT-2:0], fire};
   assign out_valid_o   = tracker_q[LAT-1];
   assign act_fire_o    = fire;
   assign weight_addr_o = waddr_q;

`ifdef MAC_ERR_STATS_EN
   logic [ERR_W-1:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == StIdle && start_i) begin
         err_d = '0;
      end else if (out_valid_o && col_error_i && (err_q != '1)) begin
         err_d = err_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= '0;
      else     err_q <= err_d;
   end

   assign err_count_o = err_q;
`else
   logic unused_col_error;
   assign unused_col_error = col_error_i;
   assign err_count_o      = '0;
`endif

endmodule

// File: tb/tb_mac_group_sequencer.sv
// Directed bench for mac_group_sequencer with one group (NM = LAT = 4).
module tb_mac_group_sequencer;
   localparam int unsigned NG    = 1;
   localparam int unsigned LEN_W = 8;
   localparam int unsigned ERR_W = 16;
   localparam int unsigned AW    = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_i = 1'b0;
   logic [LEN_W-1:0] vec_len_i = '0;
   logic             busy_o, done_o, weight_we_o;
   logic [AW-1:0]    weight_addr_o;
   logic             act_valid_i = 1'b0;
   logic             act_ready_o, act_fire_o, delay_clk_en_o;
   logic             col_error_i = 1'b0;
   logic             out_valid_o;
   logic [ERR_W-1:0] err_count_o;

   mac_group_sequencer #(
      .NUM_GROUPS (NG),
      .LEN_W      (LEN_W),
      .ERR_W      (ERR_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .vec_len_i      (vec_len_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .weight_we_o    (weight_we_o),
      .weight_addr_o  (weight_addr_o),
      .act_valid_i    (act_valid_i),
      .act_ready_o    (act_ready_o),
      .act_fire_o     (act_fire_o),
      .delay_clk_en_o (delay_clk_en_o),
      .col_error_i    (col_error_i),
      .out_valid_o    (out_valid_o),
      .err_count_o    (err_count_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int s = 0;
   int n_checks = 0;
   int n_pass = 0;
   int fire_q[$], ov_q[$], wa_q[$], wa_cyc_q[$], done_q[$];
   int dclk_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log, offsets relative to the cycle the current job's start was driven
   always @(negedge clk) begin
      if (!rst) begin
         if (act_fire_o) fire_q.push_back(cyc - s);
         if (out_valid_o) ov_q.push_back(cyc - s);
         if (weight_we_o) begin
            wa_q.push_back(int'(weight_addr_o));
            wa_cyc_q.push_back(cyc - s);
         end
         if (done_o) done_q.push_back(cyc - s);
         if (delay_clk_en_o) dclk_n++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic clear_logs();
      fire_q.delete();
      ov_q.delete();
      wa_q.delete();
      wa_cyc_q.delete();
      done_q.delete();
      dclk_n = 0;
   endtask

   task automatic goto(input int k);
      while (cyc < s + k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_job(input int len);
      clear_logs();
      s         = cyc;
      start_i   = 1'b1;
      vec_len_i = LEN_W'(len);
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      bit got = 1'b0;
      for (int i = 0; i < limit && !got; i++) begin
         @(negedge clk);
         if (done_o) got = 1'b1;
      end
      check(tag, 32'(got), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_err;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_done", 32'(done_o), 0);
      check("rst_we", 32'(weight_we_o), 0);
      check("rst_ready", 32'(act_ready_o), 0);
      check("rst_ov", 32'(out_valid_o), 0);
      check("rst_dclk", 32'(delay_clk_en_o), 0);
      check("rst_err", 32'(err_count_o), 0);
      @(posedge clk);
      #1;

      // Reset mid-STREAM after two accepted vectors
      act_valid_i = 1'b1;
      start_job(5);
      goto(7);
      check("abort_fires", fire_q.size(), 2);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy_o), 0);
      check("abort_ov", 32'(out_valid_o), 0);
      check("abort_fire", 32'(act_fire_o), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("abort_no_ov", ov_q.size(), 0);
      check("abort_no_done", done_q.size(), 0);
      start_job(2);
      wait_done("clean_timeout", 40);
      check("clean_fires", fire_q.size(), 2);
      check("clean_fire0", fire_q[0], 5);
      check("clean_ov0", ov_q[0], 9);
      check("clean_ov1", ov_q[1], 10);
      check("clean_done", done_q[0], 12);

      // vec_len=3, act_valid held high
      start_job(3);
      wait_done("job3_timeout", 40);
      check("job3_we_cnt", wa_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("job3_waddr", wa_q[i], i);
         check("job3_wcyc", wa_cyc_q[i], i + 1);
      end
      check("job3_fires", fire_q.size(), 3);
      check("job3_fire0", fire_q[0], 5);
      check("job3_ov_cnt", ov_q.size(), 3);
      check("job3_ov0", ov_q[0], 9);
      check("job3_ov1", ov_q[1], 10);
      check("job3_ov2", ov_q[2], 11);
      check("job3_done", done_q[0], 13);
      check("job3_done_cnt", done_q.size(), 1);
      check("job3_dclk", dclk_n, 8);

      // vec_len=4 with bubbles 1,0,1,0,1,1
      act_valid_i = 1'b0;
      start_job(4);
      goto(5); act_valid_i = 1'b1;
      goto(6); act_valid_i = 1'b0;
      goto(7); act_valid_i = 1'b1;
      goto(8); act_valid_i = 1'b0;
      goto(9); act_valid_i = 1'b1;
      goto(11); act_valid_i = 1'b0;
      wait_done("bub_timeout", 40);
      check("bub_fires", fire_q.size(), 4);
      check("bub_ov_cnt", ov_q.size(), 4);
      check("bub_ov0", ov_q[0], 9);
      check("bub_ov1", ov_q[1], 11);
      check("bub_ov2", ov_q[2], 13);
      check("bub_ov3", ov_q[3], 14);
      check("bub_done", done_q[0], 16);

      // vec_len=0 goes straight from weight load to drain
      start_job(0);
      wait_done("zero_timeout", 40);
      check("zero_we_cnt", wa_q.size(), 4);
      check("zero_fires", fire_q.size(), 0);
      check("zero_ov", ov_q.size(), 0);
      check("zero_done", done_q[0], 6);
      check("zero_done_cnt", done_q.size(), 1);
      check("zero_dclk", dclk_n, 1);

      // start pulses during STREAM and DONE are ignored; vec_len change has no effect
      act_valid_i = 1'b1;
      start_job(3);
      goto(6); start_i = 1'b1; vec_len_i = 8'd7;
      goto(7); start_i = 1'b0;
      goto(13); start_i = 1'b1;
      wait_done("ign_timeout", 20);
      start_i = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("ign_fires", fire_q.size(), 3);
      check("ign_ov", ov_q.size(), 3);
      check("ign_done_cnt", done_q.size(), 1);
      check("ign_we_cnt", wa_q.size(), 4);
      check("ign_busy", 32'(busy_o), 0);

      // Error stats: col_error on results 2 and 5 plus once with no valid result
`ifdef MAC_ERR_STATS_EN
      exp_err = 2;
`else
      exp_err = 0;
`endif
      start_job(6);
      goto(6); col_error_i = 1'b1;
      goto(7); col_error_i = 1'b0;
      goto(10); col_error_i = 1'b1;
      goto(11); col_error_i = 1'b0;
      goto(13); col_error_i = 1'b1;
      goto(14); col_error_i = 1'b0;
      wait_done("err_timeout", 40);
      check("err_ov_cnt", ov_q.size(), 6);
      check("err_done", done_q[0], 16);
      check("err_count", 32'(err_count_o), exp_err);
      repeat (3) @(posedge clk);
      #1;
      check("err_hold", 32'(err_count_o), exp_err);
      act_valid_i = 1'b0;
      start_job(0);
      @(negedge clk);
      check("err_clear", 32'(err_count_o), 0);
      wait_done("err2_timeout", 40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
